// File: rtl/prau_pkg.sv
// Shared PRAU operator encoding plus the quire-sequencer state, idle operator and latency helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package prau_pkg;

  // PRAU operator encoding; quire ops occupy the low codes, the rest are plain posit ops.
  typedef enum logic [3:0] {
    QCLR   = 4'h0,
    QNEG   = 4'h1,
    QMADD  = 4'h2,
    QMSUB  = 4'h3,
    QROUND = 4'h4,
    PADD   = 4'h5,
    PSUB   = 4'h6,
    PMUL   = 4'h7,
    PDIV   = 4'h8,
    PNOP   = 4'hF
  } prau_op_e;

  // Operator presented to the quire datapath whenever no quire instruction is executing.
  localparam prau_op_e QUIRE_IDLE_OP = PNOP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } quire_ctrl_state_e;

  function automatic logic is_quire_op(input prau_op_e op);
    return (op == QCLR) || (op == QNEG) || (op == QMADD) ||
           (op == QMSUB) || (op == QROUND);
  endfunction

  // Number of EXEC cycles an operator occupies; unknown operators take a single cycle.
  function automatic int unsigned quire_op_latency(input prau_op_e    op,
                                                   input int unsigned mac_lat,
                                                   input int unsigned round_lat);
    unique case (op)
      QMADD, QMSUB: return mac_lat;
      QROUND:       return round_lat;
      default:      return 1;
    endcase
  endfunction

endpackage

// File: rtl/prau_quire_ctrl.sv
// Sequencer that serialises quire instructions in front of the PRAU quire datapath; optional perf counters via PRAU_QUIRE_PERF_EN.
// Latency: accept -> LAT EXEC cycles -> response one cycle later (1 / MAC_LATENCY / ROUND_LATENCY by operator).
// Backpressure: one instruction in flight; in_ready_o only in IDLE or when the held response is consumed; flush_i blocks acceptance.
module prau_quire_ctrl
  import prau_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned MAC_LATENCY   = 4,
  parameter int unsigned ROUND_LATENCY = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  prau_op_e        operator_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output prau_op_e        dp_operator_o,
  output logic [XLEN-1:0] dp_operand_a_o,
  output logic [XLEN-1:0] dp_operand_b_o,
  output logic            dp_input_hs_o,
  output logic            dp_out_valid_o,
  input  logic [XLEN-1:0] dp_result_i
`ifdef PRAU_QUIRE_PERF_EN
  ,
  output logic [31:0]     perf_mac_cnt_o,
  output logic [31:0]     perf_stall_cnt_o
`endif
);

  localparam int unsigned MAX_LAT = (MAC_LATENCY > ROUND_LATENCY) ? MAC_LATENCY : ROUND_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  quire_ctrl_state_e state_q, state_d;
  prau_op_e          op_q;
  logic [XLEN-1:0]   opa_q, opb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   res_q;

  logic accept;
  logic exec_last;
  logic exec_done;

  assign in_ready_o = ((state_q == IDLE) || ((state_q == RESP) && out_ready_i)) && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign exec_last  = (state_q == EXEC) && (cnt_q == '0);
  // A flush on the final EXEC cycle cancels the strobe and the result capture.
  assign exec_done  = exec_last && !flush_i;

  assign out_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign result_o    = res_q;

  // State register; reset returns to IDLE immediately, which also kills pending strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath drive; strobes fire only on the last EXEC cycle.
  always_comb begin
    state_d        = state_q;
    dp_operator_o  = QUIRE_IDLE_OP;
    dp_operand_a_o = '0;
    dp_operand_b_o = '0;
    dp_input_hs_o  = 1'b0;
    dp_out_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        // The operator is driven even while flushing: a QCLR clears by operator alone.
        dp_operator_o  = is_quire_op(op_q) ? op_q : QUIRE_IDLE_OP;
        dp_operand_a_o = opa_q;
        dp_operand_b_o = opb_q;
        if (exec_done) begin
          dp_input_hs_o  = (op_q == QNEG);
          dp_out_valid_o = (op_q == QMADD) || (op_q == QMSUB);
        end
        if (flush_i) begin
          state_d = IDLE;
        end else if (exec_last) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (out_ready_i) begin
          state_d = accept ? EXEC : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Instruction capture on accept and the EXEC down-counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q  <= QCLR;
      opa_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      op_q  <= operator_i;
      opa_q <= operand_a_i;
      opb_q <= operand_b_i;
      cnt_q <= CNT_W'(quire_op_latency(operator_i, MAC_LATENCY, ROUND_LATENCY) - 1);
    end else if ((state_q == EXEC) && (cnt_q != '0) && !flush_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Response capture: only QROUND returns datapath data, everything else answers 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else if (exec_done) begin
      res_q <= (op_q == QROUND) ? dp_result_i : '0;
    end
  end

`ifdef PRAU_QUIRE_PERF_EN
  // Saturating counters for MAC write-backs and stalled request cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_mac_cnt_o   <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (dp_out_valid_o && (perf_mac_cnt_o != 32'hFFFF_FFFF)) begin
        perf_mac_cnt_o <= perf_mac_cnt_o + 32'd1;
      end
      if (in_valid_i && !in_ready_o && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prau_quire_ctrl.sv
// Directed bench for prau_quire_ctrl with a behavioural quire datapath stand-in and a response scoreboard.
// Latency: checks exact EXEC/RESP cycle placement for MAC_LATENCY=4, ROUND_LATENCY=3.
// Backpressure: exercises held responses, back-to-back accept, flush and mid-operation reset.
module tb_prau_quire_ctrl;
  import prau_pkg::*;

  localparam int unsigned XLEN = 64;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            in_valid_i;
  logic            in_ready_o;
  prau_op_e        operator_i;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;
  prau_op_e        dp_operator_o;
  logic [XLEN-1:0] dp_operand_a_o;
  logic [XLEN-1:0] dp_operand_b_o;
  logic            dp_input_hs_o;
  logic            dp_out_valid_o;
  logic [XLEN-1:0] dp_result_i;
`ifdef PRAU_QUIRE_PERF_EN
  logic [31:0]     perf_mac_cnt_o;
  logic [31:0]     perf_stall_cnt_o;
`endif

  prau_quire_ctrl #(.XLEN(XLEN), .MAC_LATENCY(4), .ROUND_LATENCY(3)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .operator_i     (operator_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .flush_i        (flush_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .result_o       (result_o),
    .busy_o         (busy_o),
    .dp_operator_o  (dp_operator_o),
    .dp_operand_a_o (dp_operand_a_o),
    .dp_operand_b_o (dp_operand_b_o),
    .dp_input_hs_o  (dp_input_hs_o),
    .dp_out_valid_o (dp_out_valid_o),
    .dp_result_i    (dp_result_i)
`ifdef PRAU_QUIRE_PERF_EN
    ,
    .perf_mac_cnt_o   (perf_mac_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q[$];

  // Quire datapath stand-in: its own state, untouched by rst_i; "rounding" is plain pass-through.
  logic [XLEN-1:0] quire_q     = 64'h0000_0000_0000_1234;
  int              mac_pulses  = 0;
  int              neg_pulses  = 0;
  logic            force_en    = 1'b0;
  logic [XLEN-1:0] force_val   = '0;

  assign dp_result_i = force_en ? force_val : quire_q;

  always @(posedge clk_i) begin
    if (dp_operator_o == QCLR) begin
      quire_q <= '0;
    end else if (dp_out_valid_o) begin
      if (dp_operator_o == QMADD) quire_q <= quire_q + dp_operand_a_o * dp_operand_b_o;
      else                        quire_q <= quire_q - dp_operand_a_o * dp_operand_b_o;
    end else if (dp_input_hs_o) begin
      quire_q <= -quire_q;
    end
    if (dp_out_valid_o) mac_pulses <= mac_pulses + 1;
    if (dp_input_hs_o)  neg_pulses <= neg_pulses + 1;
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every consumed response must match the oldest expected one.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got 0x%h expected no response", result_o);
      end else begin
        chk("resp", result_o, exp_q.pop_front());
      end
    end
  end

  // Present a request and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic accept_op(input prau_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input bit push, input logic [XLEN-1:0] exp);
    bit ok = 0;
    in_valid_i  = 1'b1;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (in_ready_o) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got in_ready_o=0 expected 1 within 20 cycles");
    end
    @(posedge clk_i);
    if (push) exp_q.push_back(exp);
    #1;
    in_valid_i  = 1'b0;
    operand_a_i = 64'hDEAD_BEEF_DEAD_BEEF;
    operand_b_i = 64'hBAD0_BAD0_BAD0_BAD0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: got busy_o=1 expected 0 within 30 cycles");
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_op(input prau_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp);
    accept_op(op, a, b, 1'b1, exp);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    operator_i  = QCLR;
    operand_a_i = '0;
    operand_b_i = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    #22;
    // Reset state
    chk("rst_busy", busy_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_dp_op", dp_operator_o, QUIRE_IDLE_OP);
    chk("rst_result", result_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("idle_in_ready", in_ready_o, 1);
    @(posedge clk_i); #1;

    // QCLR: operator visible in cycle 1 only, no strobes, response 0 in cycle 2
    accept_op(QCLR, 64'h11, 64'h22, 1'b1, 64'h0);
    @(negedge clk_i);
    chk("qclr_dp_op", dp_operator_o, QCLR);
    chk("qclr_mac_strobe", dp_out_valid_o, 0);
    chk("qclr_hs_strobe", dp_input_hs_o, 0);
    @(negedge clk_i);
    chk("qclr_out_valid", out_valid_o, 1);
    chk("qclr_dp_op_resp", dp_operator_o, QUIRE_IDLE_OP);
    wait_idle();
    chk("qclr_quire", quire_q, 0);

    // QMADD 0x40000000*0x40000000: strobe only on cycle 4, operands held cycles 1-4
    accept_op(QMADD, 64'h4000_0000, 64'h4000_0000, 1'b1, 64'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      chk("qmadd_strobe", dp_out_valid_o, (c == 4));
      chk("qmadd_opa", dp_operand_a_o, 64'h4000_0000);
      chk("qmadd_opb", dp_operand_b_o, 64'h4000_0000);
      chk("qmadd_out_valid", out_valid_o, 0);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("qmadd_resp_valid", out_valid_o, 1);
    wait_idle();
    chk("qmadd_pulses", mac_pulses, 1);

    // QROUND of 2^60
    run_op(QROUND, 64'h0, 64'h0, 64'h1000_0000_0000_0000);

    // QNEG: exactly one input-handshake pulse on its single EXEC cycle
    accept_op(QNEG, 64'h0, 64'h0, 1'b1, 64'h0);
    @(negedge clk_i);
    chk("qneg_hs", dp_input_hs_o, 1);
    chk("qneg_no_mac", dp_out_valid_o, 0);
    wait_idle();
    chk("qneg_pulses", neg_pulses, 1);
    chk("qneg_quire", quire_q, 64'hF000_0000_0000_0000);

    // QROUND with the datapath presenting 0xC0000000
    force_en  = 1'b1;
    force_val = 64'h0000_0000_C000_0000;
    run_op(QROUND, 64'h0, 64'h0, 64'h0000_0000_C000_0000);
    force_en  = 1'b0;

    // Held response with a second request pending, then back-to-back accept
    out_ready_i = 1'b0;
    accept_op(QROUND, 64'h0, 64'h0, 1'b1, 64'hF000_0000_0000_0000);
    in_valid_i  = 1'b1;
    operator_i  = QMSUB;
    operand_a_i = 64'h1;
    operand_b_i = 64'h2;
    begin
      bit ok = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk_i);
        if (out_valid_o) begin ok = 1; break; end
      end
      chk("bp_reach_resp", ok, 1);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk_i);
      chk("bp_in_ready", in_ready_o, 0);
      chk("bp_out_valid", out_valid_o, 1);
      chk("bp_result", result_o, 64'hF000_0000_0000_0000);
    end
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("b2b_in_ready", in_ready_o, 1);
    @(posedge clk_i);
    exp_q.push_back(64'h0);
    #1;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_busy", busy_o, 1);
    chk("b2b_dp_op", dp_operator_o, QMSUB);
    chk("b2b_out_valid", out_valid_o, 0);
    wait_idle();
    chk("qmsub_quire", quire_q, 64'hEFFF_FFFF_FFFF_FFFE);

    // Flush a QMADD in its second EXEC cycle
    accept_op(QMADD, 64'h3, 64'h5, 1'b0, 64'h0);
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_no_strobe", dp_out_valid_o, 0);
    chk("flush_in_ready", in_ready_o, 0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_busy", busy_o, 0);
    chk("flush_no_resp", out_valid_o, 0);
    @(posedge clk_i); #1;
    chk("flush_pulses", mac_pulses, 2);
    run_op(QROUND, 64'h0, 64'h0, 64'hEFFF_FFFF_FFFF_FFFE);

    // Non-quire operator: idle operator to datapath, result 0 after one EXEC cycle
    accept_op(PADD, 64'h7, 64'h9, 1'b1, 64'h0);
    @(negedge clk_i);
    chk("illegal_dp_op", dp_operator_o, QUIRE_IDLE_OP);
    chk("illegal_no_strobe", dp_out_valid_o | dp_input_hs_o, 0);
    @(negedge clk_i);
    chk("illegal_resp_valid", out_valid_o, 1);
    wait_idle();

    // QCLR flushed on its only EXEC cycle still clears the quire
    accept_op(QCLR, 64'h0, 64'h0, 1'b0, 64'h0);
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("qclr_flush_dp_op", dp_operator_o, QCLR);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("qclr_flush_busy", busy_o, 0);
    @(posedge clk_i); #1;
    run_op(QROUND, 64'h0, 64'h0, 64'h0);

    // Asynchronous reset during QMSUB EXEC
    accept_op(QMSUB, 64'h1, 64'h1, 1'b0, 64'h0);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_out_valid", out_valid_o, 0);
    chk("arst_dp_op", dp_operator_o, QUIRE_IDLE_OP);
    chk("arst_dp_opa", dp_operand_a_o, 0);
    chk("arst_strobes", dp_out_valid_o | dp_input_hs_o, 0);
    chk("arst_result", result_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #1;
    chk("arst_pulses", mac_pulses, 2);
    chk("arst_quire", quire_q, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
